ccff_loader: RTL

Configuration-chain driver that sits at the `ccff_head` end of the fabric's configuration flip-flop chain and is the producing side of that interface. It accepts bitstream words over a valid/ready handshake, serialises them MSB-first onto `ccff_head`, and drives a shift-enable for the external `prog_clk` gate so the chain advances only on valid bits. In verify mode it compares the bits returning on `ccff_tail` against the re-sent stream and counts mismatches.

---
 rtl/ccff_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/ccff_loader.sv
// ccff_loader: serialises bitstream words MSB-first onto the configuration chain head,
// gating prog_clk via shift_en, and optionally counts mismatches on the returning tail.
module ccff_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              verify,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  mismatch_cnt
);
    localparam int REM_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FINISH
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              verify_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  mismatch_q;
    logic [REM_W-1:0]  rem_q;
    logic [WORD_W-1:0] shreg_q;

    logic        loading;
    logic        outstanding;
    logic        last_shift;
    logic        accept;
    logic        mismatch_bit;
    logic [31:0] fetched;

    assign loading      = (state_q == ST_LOAD);
    assign shift_en     = loading && (rem_q != '0);
    assign ccff_head    = shreg_q[WORD_W-1];
    // Bits already shifted plus bits still waiting in the word register.
    assign fetched      = 32'(cnt_q) + 32'(rem_q);
    assign outstanding  = (fetched < 32'(CHAIN_LEN));
    assign word_ready   = loading && outstanding &&
                          ((rem_q == '0) || ((rem_q == REM_W'(1)) && shift_en));
    assign accept       = word_ready && word_valid;
    assign last_shift   = shift_en && (32'(cnt_q) == 32'(CHAIN_LEN - 1));
    assign mismatch_bit = verify_q && (ccff_tail != ccff_head);

    assign busy         = busy_q;
    assign done         = done_q;
    assign mismatch_cnt = mismatch_q;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            verify_q   <= 1'b0;
            cnt_q      <= '0;
            mismatch_q <= '0;
            rem_q      <= '0;
            shreg_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q    <= ST_LOAD;
                        busy_q     <= 1'b1;
                        verify_q   <= verify;
                        cnt_q      <= '0;
                        mismatch_q <= '0;
                        rem_q      <= '0;
                    end
                end
                ST_LOAD: begin
                    if (shift_en) begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
                        rem_q   <= rem_q - REM_W'(1);
                        if (mismatch_bit && (mismatch_q != {CNT_W{1'b1}})) begin
                            mismatch_q <= mismatch_q + CNT_W'(1);
                        end
                        // A partial final word leaves unused low bits behind; drop them.
                        if (last_shift) begin
                            rem_q   <= '0;
                            state_q <= ST_FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    if (accept) begin
                        shreg_q <= word_data;
                        rem_q   <= REM_W'(WORD_W);
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule
